// File: rtl/ddr3_cmd_timer.sv
// DDR3 command timing stage: spaces init/refresh commands and arbitrates the user port.
// Optional DDR3_SHORT_ZQ_EN shortens the ZQCL wait to 64 cycles for fast simulation.
module ddr3_cmd_timer #(
    parameter int DDR_ROW_BITS = 13,
    parameter int CMOD         = 12,
    parameter int CZQINIT      = 512,
    parameter int CRP          = 3,
    parameter int CRFC         = 11
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    cfg_req_i,
    input  logic [2:0]              cfg_cmd_i,
    input  logic [2:0]              cfg_ba_i,
    input  logic [DDR_ROW_BITS-1:0] cfg_adr_i,
    input  logic                    cfg_run_i,
    input  logic                    cfg_ref_i,
    output logic                    cfg_rdy_o,
    input  logic                    usr_req_i,
    input  logic [2:0]              usr_cmd_i,
    input  logic [2:0]              usr_ba_i,
    input  logic [DDR_ROW_BITS-1:0] usr_adr_i,
    output logic                    usr_rdy_o,
    output logic                    dfi_ras_no,
    output logic                    dfi_cas_no,
    output logic                    dfi_we_no,
    output logic [2:0]              dfi_ba_o,
    output logic [DDR_ROW_BITS-1:0] dfi_adr_o
);

    localparam int TW = $clog2(CZQINIT + 1);
`ifdef DDR3_SHORT_ZQ_EN
    localparam int ZQ_WAIT = 64;
`else
    localparam int ZQ_WAIT = CZQINIT;
`endif

    localparam logic [2:0] CMD_MODE = 3'b000;
    localparam logic [2:0] CMD_REFR = 3'b001;
    localparam logic [2:0] CMD_PREC = 3'b010;
    localparam logic [2:0] CMD_ZQCL = 3'b110;
    localparam logic [2:0] CMD_NOOP = 3'b111;

    localparam logic [TW-1:0] T_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] T_ONE  = TW'(1);
    localparam logic [TW-1:0] T_HOLD = TW'(2);
    localparam logic [DDR_ROW_BITS-1:0] ADR_ALL_BANKS =
        {{(DDR_ROW_BITS-11){1'b0}}, 1'b1, 10'b0000000000};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_RPRE = 3'd2,
        S_RREF = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [TW-1:0]           timer_q, timer_d, timer_dec_s;
    logic [2:0]              cmd_q, cmd_d;
    logic [2:0]              ba_q, ba_d;
    logic [DDR_ROW_BITS-1:0] adr_q, adr_d;
    logic                    cfg_rdy_q, cfg_rdy_d;
    logic                    usr_rdy_q, usr_rdy_d;

    function automatic logic [TW-1:0] cfg_wait(input logic [2:0] cmd);
        case (cmd)
            CMD_MODE: cfg_wait = TW'(CMOD);
            CMD_ZQCL: cfg_wait = TW'(ZQ_WAIT);
            CMD_PREC: cfg_wait = TW'(CRP);
            CMD_REFR: cfg_wait = TW'(CRFC);
            default:  cfg_wait = T_ONE;
        endcase
    endfunction

    // Only MODE/REFR/PREC/ZQCL are legal init commands; the rest go out as NOOP.
    function automatic logic cfg_cmd_real(input logic [2:0] cmd);
        case (cmd)
            CMD_MODE, CMD_REFR, CMD_PREC, CMD_ZQCL: cfg_cmd_real = 1'b1;
            default:                                cfg_cmd_real = 1'b0;
        endcase
    endfunction

    assign timer_dec_s = (timer_q != T_ZERO) ? (timer_q - T_ONE) : T_ZERO;
    assign usr_rdy_o   = usr_rdy_q & cfg_run_i & ~cfg_ref_i;
    assign cfg_rdy_o   = cfg_rdy_q;
    assign dfi_ras_no  = cmd_q[2];
    assign dfi_cas_no  = cmd_q[1];
    assign dfi_we_no   = cmd_q[0];
    assign dfi_ba_o    = ba_q;
    assign dfi_adr_o   = adr_q;

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            timer_q   <= T_ZERO;
            cmd_q     <= CMD_NOOP;
            ba_q      <= 3'b000;
            adr_q     <= {DDR_ROW_BITS{1'b0}};
            cfg_rdy_q <= 1'b0;
            usr_rdy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            cmd_q     <= cmd_d;
            ba_q      <= ba_d;
            adr_q     <= adr_d;
            cfg_rdy_q <= cfg_rdy_d;
            usr_rdy_q <= usr_rdy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!cfg_run_i) begin
                    state_d = cfg_req_i ? S_WAIT : S_IDLE;
                end else begin
                    state_d = cfg_ref_i ? S_RPRE : S_IDLE;
                end
            end
            S_WAIT:  state_d = (timer_q <= T_ONE)  ? S_IDLE : S_WAIT;
            S_RPRE:  state_d = (timer_q == T_ZERO) ? S_RREF : S_RPRE;
            S_RREF:  state_d = (timer_q <= T_ONE)  ? S_HOLD : S_RREF;
            S_HOLD:  state_d = (timer_q == T_ZERO) ? S_IDLE : S_HOLD;
            default: state_d = S_IDLE;
        endcase
    end

    // Command, timer and ready outputs; HOLD spans the rdy pulse plus two cycles
    always_comb begin
        cmd_d     = CMD_NOOP;
        ba_d      = ba_q;
        adr_d     = adr_q;
        timer_d   = timer_dec_s;
        cfg_rdy_d = 1'b0;
        usr_rdy_d = (state_d == S_IDLE) & cfg_run_i;
        case (state_q)
            S_IDLE: begin
                if (!cfg_run_i) begin
                    if (cfg_req_i) begin
                        timer_d = cfg_wait(cfg_cmd_i);
                        if (cfg_cmd_real(cfg_cmd_i)) begin
                            cmd_d = cfg_cmd_i;
                            ba_d  = cfg_ba_i;
                            adr_d = cfg_adr_i;
                        end else begin
                            cmd_d = CMD_NOOP;
                        end
                    end else begin
                        cfg_rdy_d = 1'b1;
                    end
                end else if (cfg_ref_i) begin
                    cmd_d   = CMD_PREC;
                    adr_d   = ADR_ALL_BANKS;
                    timer_d = TW'(CRP);
                end else if (usr_req_i && usr_rdy_o) begin
                    cmd_d = usr_cmd_i;
                    ba_d  = usr_ba_i;
                    adr_d = usr_adr_i;
                end else begin
                    cmd_d = CMD_NOOP;
                end
            end
            S_WAIT: begin
                cfg_rdy_d = (timer_q <= T_ONE);
            end
            S_RPRE: begin
                if (timer_q == T_ZERO) begin
                    cmd_d   = CMD_REFR;
                    timer_d = TW'(CRFC);
                end else begin
                    cmd_d = CMD_NOOP;
                end
            end
            S_RREF: begin
                if (timer_q <= T_ONE) begin
                    cfg_rdy_d = 1'b1;
                    timer_d   = T_HOLD;
                end else begin
                    cfg_rdy_d = 1'b0;
                end
            end
            S_HOLD: begin
                cfg_rdy_d = 1'b0;
            end
            default: begin
                cmd_d = CMD_NOOP;
            end
        endcase
    end

endmodule

// File: tb/tb_ddr3_cmd_timer.sv
// Directed bench for ddr3_cmd_timer: init command spacing, refresh sequence, user arbitration, reset.
module tb_ddr3_cmd_timer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_req_i = 1'b0;
    logic [2:0]  cfg_cmd_i = 3'b111;
    logic [2:0]  cfg_ba_i = 3'b000;
    logic [12:0] cfg_adr_i = 13'h0000;
    logic        cfg_run_i = 1'b0;
    logic        cfg_ref_i = 1'b0;
    logic        cfg_rdy_o;
    logic        usr_req_i = 1'b0;
    logic [2:0]  usr_cmd_i = 3'b111;
    logic [2:0]  usr_ba_i = 3'b000;
    logic [12:0] usr_adr_i = 13'h0000;
    logic        usr_rdy_o;
    logic        dfi_ras_no, dfi_cas_no, dfi_we_no;
    logic [2:0]  dfi_ba_o;
    logic [12:0] dfi_adr_o;

    int n_assert = 0;
    int n_fail = 0;

`ifdef DDR3_SHORT_ZQ_EN
    localparam int ZQ_LAT = 65;
`else
    localparam int ZQ_LAT = 513;
`endif

    ddr3_cmd_timer dut (
        .clock(clock), .reset_n(reset_n),
        .cfg_req_i(cfg_req_i), .cfg_cmd_i(cfg_cmd_i), .cfg_ba_i(cfg_ba_i), .cfg_adr_i(cfg_adr_i),
        .cfg_run_i(cfg_run_i), .cfg_ref_i(cfg_ref_i), .cfg_rdy_o(cfg_rdy_o),
        .usr_req_i(usr_req_i), .usr_cmd_i(usr_cmd_i), .usr_ba_i(usr_ba_i), .usr_adr_i(usr_adr_i),
        .usr_rdy_o(usr_rdy_o),
        .dfi_ras_no(dfi_ras_no), .dfi_cas_no(dfi_cas_no), .dfi_we_no(dfi_we_no),
        .dfi_ba_o(dfi_ba_o), .dfi_adr_o(dfi_adr_o)
    );

    always #5 clock = ~clock;

    function automatic logic [2:0] dfi_cmd();
        return {dfi_ras_no, dfi_cas_no, dfi_we_no};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one config command in the current cycle and measure cycles until cfg_rdy_o.
    task automatic issue_cfg(input string tag, input logic [2:0] cmd, input logic [2:0] ba,
                             input logic [12:0] adr, input logic [2:0] exp_cmd, input int exp_lat);
        int lat;
        int extra;
        cfg_req_i = 1'b1;
        cfg_cmd_i = cmd;
        cfg_ba_i  = ba;
        cfg_adr_i = adr;
        tick();
        cfg_req_i = 1'b0;
        #1;
        chk({tag, "_cmd"}, 32'(dfi_cmd()), 32'(exp_cmd));
        chk({tag, "_rdy_low"}, 32'(cfg_rdy_o), 32'd0);
        if (exp_cmd != 3'b111) begin
            chk({tag, "_ba"}, 32'(dfi_ba_o), 32'(ba));
            chk({tag, "_adr"}, 32'(dfi_adr_o), 32'(adr));
        end
        lat = 1;
        extra = 0;
        while (cfg_rdy_o !== 1'b1 && lat < 2000) begin
            tick();
            #1;
            lat++;
            if (dfi_cmd() !== 3'b111) extra++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_noop_after"}, 32'(extra), 32'd0);
    endtask

    initial begin
        int prec_k, refr_k, rdy_k, rdy_cnt, usr_k, ncmd, act_k;

        // Reset held three cycles
        repeat (3) tick();
        #1;
        chk("rst_cmd", 32'(dfi_cmd()), 32'h7);
        chk("rst_ba", 32'(dfi_ba_o), 32'h0);
        chk("rst_adr", 32'(dfi_adr_o), 32'h0);
        chk("rst_cfg_rdy", 32'(cfg_rdy_o), 32'h0);
        chk("rst_usr_rdy", 32'(usr_rdy_o), 32'h0);

        reset_n = 1'b1;
        tick();
        #1;
        chk("idle_cfg_rdy", 32'(cfg_rdy_o), 32'h1);

        issue_cfg("mode", 3'b000, 3'd2, 13'h0008, 3'b000, 13);
        issue_cfg("prec", 3'b010, 3'd1, 13'h0400, 3'b010, 4);
        issue_cfg("refr", 3'b001, 3'd0, 13'h0000, 3'b001, 12);
        issue_cfg("act_as_noop", 3'b011, 3'd6, 13'h1abc, 3'b111, 2);
        chk("act_adr_hold", 32'(dfi_adr_o), 32'h0);
        issue_cfg("zqcl", 3'b110, 3'd0, 13'h0400, 3'b110, ZQ_LAT);

        // Enter run mode
        cfg_run_i = 1'b1;
        tick();
        #1;
        chk("run_cfg_rdy", 32'(cfg_rdy_o), 32'h0);
        chk("run_usr_rdy", 32'(usr_rdy_o), 32'h1);

        // Back-to-back user commands
        usr_req_i = 1'b1; usr_cmd_i = 3'b101; usr_ba_i = 3'd3; usr_adr_i = 13'h0055;
        tick();
        usr_cmd_i = 3'b100; usr_ba_i = 3'd4; usr_adr_i = 13'h0123;
        #1;
        chk("usr_read_cmd", 32'(dfi_cmd()), 32'h5);
        chk("usr_read_adr", 32'(dfi_adr_o), 32'h55);
        tick();
        usr_req_i = 1'b0;
        #1;
        chk("usr_writ_cmd", 32'(dfi_cmd()), 32'h4);
        chk("usr_writ_ba", 32'(dfi_ba_o), 32'h4);
        tick();
        #1;
        chk("usr_idle_cmd", 32'(dfi_cmd()), 32'h7);

        // Refresh with ref held through T+18
        cfg_ref_i = 1'b1;
        #1;
        chk("ref_usr_rdy_T", 32'(usr_rdy_o), 32'h0);
        prec_k = 0; refr_k = 0; rdy_k = 0; rdy_cnt = 0; usr_k = 0; ncmd = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 19) cfg_ref_i = 1'b0;
            #1;
            if (dfi_cmd() !== 3'b111) ncmd++;
            if (dfi_cmd() === 3'b010 && dfi_adr_o[10] === 1'b1 && prec_k == 0) prec_k = k;
            if (dfi_cmd() === 3'b001 && refr_k == 0) refr_k = k;
            if (cfg_rdy_o === 1'b1) begin rdy_cnt++; if (rdy_k == 0) rdy_k = k; end
            if (usr_rdy_o === 1'b1 && usr_k == 0) usr_k = k;
        end
        chk("ref_prec_k", 32'(prec_k), 32'd1);
        chk("ref_refr_k", 32'(refr_k), 32'd5);
        chk("ref_rdy_k", 32'(rdy_k), 32'd16);
        chk("ref_rdy_cnt", 32'(rdy_cnt), 32'd1);
        chk("ref_usr_rdy_k", 32'(usr_k), 32'd19);
        chk("ref_ncmd", 32'(ncmd), 32'd2);

        // Refresh and user request in the same cycle
        cfg_ref_i = 1'b1;
        usr_req_i = 1'b1; usr_cmd_i = 3'b011; usr_ba_i = 3'd5; usr_adr_i = 13'h0123;
        prec_k = 0; refr_k = 0; usr_k = 0; act_k = 0;
        for (int k = 1; k <= 21; k++) begin
            tick();
            if (k == 17) cfg_ref_i = 1'b0;
            if (k == 20) usr_req_i = 1'b0;
            #1;
            if (dfi_cmd() === 3'b010 && prec_k == 0) prec_k = k;
            if (dfi_cmd() === 3'b001 && refr_k == 0) refr_k = k;
            if (dfi_cmd() === 3'b011 && act_k == 0) act_k = k;
            if (usr_rdy_o === 1'b1 && usr_k == 0) usr_k = k;
        end
        chk("arb_prec_k", 32'(prec_k), 32'd1);
        chk("arb_refr_k", 32'(refr_k), 32'd5);
        chk("arb_usr_rdy_k", 32'(usr_k), 32'd19);
        chk("arb_act_k", 32'(act_k), 32'd20);
        chk("arb_act_adr", 32'(dfi_adr_o), 32'h123);

        // Reset in the middle of the refresh wait
        cfg_ref_i = 1'b1;
        repeat (8) tick();
        cfg_ref_i = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        chk("mid_rst_cmd", 32'(dfi_cmd()), 32'h7);
        chk("mid_rst_adr", 32'(dfi_adr_o), 32'h0);
        chk("mid_rst_cfg_rdy", 32'(cfg_rdy_o), 32'h0);
        chk("mid_rst_usr_rdy", 32'(usr_rdy_o), 32'h0);
        rdy_cnt = 0; ncmd = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            #1;
            if (cfg_rdy_o === 1'b1) rdy_cnt++;
            if (dfi_cmd() !== 3'b111) ncmd++;
        end
        chk("mid_rst_no_pulse", 32'(rdy_cnt), 32'd0);
        chk("mid_rst_no_cmd", 32'(ncmd), 32'd0);
        chk("mid_rst_usr_back", 32'(usr_rdy_o), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
